disp_sched: RTL

Transfer scheduler for the serial seven-segment display path. It arbitrates round-robin between two requesters that want to write display content, and it periodically re-sends the current content. It latches the winning request's digit, point, blink-enable and text-mode fields and issues a single-cycle `Start` to the downstream display/P2S block. It holds the latched data stable and blocks new transfers for a fixed transfer window, and it also generates the `flash` blink phase for the display.

---
 rtl/disp_sched_if.sv | 38 +++
 rtl/disp_sched.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/disp_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : disp_sched_if
// Brief    : Requester and display-side signals of the display transfer scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface disp_sched_if;
    logic        req0;
    logic        req1;
    logic [31:0] hexs0;
    logic [31:0] hexs1;
    logic [7:0]  point0;
    logic [7:0]  point1;
    logic [7:0]  les0;
    logic [7:0]  les1;
    logic        text0;
    logic        text1;
    logic        ack0;
    logic        ack1;
    logic        Start;
    logic [31:0] Hexs;
    logic [7:0]  point;
    logic [7:0]  LES;
    logic        Text;
    logic        flash;
    logic        busy;

    modport master (
        output req0, req1, hexs0, hexs1, point0, point1, les0, les1, text0, text1,
        input  ack0, ack1, Start, Hexs, point, LES, Text, flash, busy
    );

    modport slave (
        input  req0, req1, hexs0, hexs1, point0, point1, les0, les1, text0, text1,
        output ack0, ack1, Start, Hexs, point, LES, Text, flash, busy
    );
endinterface
`default_nettype wire

// File: rtl/disp_sched.sv
`default_nettype none
// ============================================================================
// Module   : disp_sched
// Brief    : Round-robin display transfer scheduler with periodic refresh.
//            Optional blink generator enabled by macro DISP_SCHED_BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module disp_sched #(
    parameter int REFRESH_DIV = 50000,
    parameter int XFER_CYCLES = 136,
    parameter int BLINK_DIV   = 25000000,
    parameter int CNT_W       = 32
) (
    input  wire logic   clk,
    input  wire logic   rst,
    disp_sched_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_XFER = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_xfer_last = CNT_W'(XFER_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_xfer_cnt;
    logic             r_last_gnt;
    logic             r_refresh_pend;
    logic             w_refresh_tick;
    logic             w_blink_tick;
    logic             w_req_any;
    logic             w_gnt1;
    logic             w_enter_load;

    assign w_req_any    = bus.req0 | bus.req1;
    // On a tie the requester not granted last wins.
    assign w_gnt1       = bus.req1 & (~bus.req0 | ~r_last_gnt);
    assign w_enter_load = (r_state == S_IDLE) & (w_req_any | r_refresh_pend);

    generate
        if (REFRESH_DIV > 0) begin : g_refresh
            localparam logic [CNT_W-1:0] c_refresh_last = CNT_W'(REFRESH_DIV - 1);
            logic [CNT_W-1:0] r_refresh_cnt;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_refresh_cnt <= '0;
                end else if (r_refresh_cnt == '0) begin
                    r_refresh_cnt <= c_refresh_last;
                end else begin
                    r_refresh_cnt <= r_refresh_cnt - c_cnt_one;
                end
            end

            assign w_refresh_tick = (r_refresh_cnt == '0);
        end else begin : g_no_refresh
            assign w_refresh_tick = 1'b0;
        end
    endgenerate

`ifdef DISP_SCHED_BLINK_EN
    localparam logic [CNT_W-1:0] c_blink_last = CNT_W'(BLINK_DIV - 1);
    logic [CNT_W-1:0] r_blink_cnt;
    logic             r_flash;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blink_cnt <= '0;
            r_flash     <= 1'b0;
        end else if (r_blink_cnt == c_blink_last) begin
            r_blink_cnt <= '0;
            r_flash     <= ~r_flash;
        end else begin
            r_blink_cnt <= r_blink_cnt + c_cnt_one;
        end
    end

    assign w_blink_tick = (r_blink_cnt == c_blink_last);
    assign bus.flash    = r_flash;
`else
    logic w_unused_blink;
    assign w_unused_blink = |BLINK_DIV;
    assign w_blink_tick   = 1'b0;
    assign bus.flash      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_xfer_cnt     <= '0;
            r_last_gnt     <= 1'b1;
            r_refresh_pend <= 1'b0;
            bus.ack0       <= 1'b0;
            bus.ack1       <= 1'b0;
            bus.Start      <= 1'b0;
            bus.busy       <= 1'b0;
            bus.Hexs       <= '0;
            bus.point      <= '0;
            bus.LES        <= '0;
            bus.Text       <= 1'b0;
        end else begin
            // Entering LOAD consumes the pending refresh, even one ticking this cycle.
            if (w_enter_load) begin
                r_refresh_pend <= 1'b0;
            end else if (w_refresh_tick | w_blink_tick) begin
                r_refresh_pend <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        r_state    <= S_LOAD;
                        r_last_gnt <= w_gnt1;
                        bus.ack0   <= ~w_gnt1;
                        bus.ack1   <= w_gnt1;
                        bus.Start  <= 1'b1;
                        bus.busy   <= 1'b1;
                        bus.Hexs   <= w_gnt1 ? bus.hexs1  : bus.hexs0;
                        bus.point  <= w_gnt1 ? bus.point1 : bus.point0;
                        bus.LES    <= w_gnt1 ? bus.les1   : bus.les0;
                        bus.Text   <= w_gnt1 ? bus.text1  : bus.text0;
                    end else if (r_refresh_pend) begin
                        r_state   <= S_LOAD;
                        bus.Start <= 1'b1;
                        bus.busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_state    <= S_XFER;
                    r_xfer_cnt <= c_xfer_last;
                    bus.Start  <= 1'b0;
                    bus.ack0   <= 1'b0;
                    bus.ack1   <= 1'b0;
                end
                S_XFER: begin
                    if (r_xfer_cnt == '0) begin
                        r_state  <= S_IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        r_xfer_cnt <= r_xfer_cnt - c_cnt_one;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    bus.Start <= 1'b0;
                    bus.ack0  <= 1'b0;
                    bus.ack1  <= 1'b0;
                    bus.busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
